rob_mw: RTL

Parametrised multi-writeback, multi-commit reorder buffer for the LEN5 execution pipeline. It sits between the issue stage, the CDB and the commit logic.
- Accepts one instruction per cycle from issue.
- Accepts up to CDB_PORTS results per cycle.
- Retires up to COMMIT_W in-order entries per cycle.
- Adds an explicit occupancy counter, CDB-to-operand forwarding and partial squash of younger entries on branch mispredict.

---
 rtl/expipe_pkg.sv | 54 +++++
 rtl/rob_mw_commit_sel.sv | 53 +++++
 rtl/rob_mw.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/expipe_pkg.sv
// -----------------------------------------------------------------------------
// expipe_pkg
// Shared types for the LEN5 execution pipeline: architectural widths, the
// exception cause encoding, the reorder-buffer entry and the CDB payload.
// No ports (package).
// -----------------------------------------------------------------------------
package expipe_pkg;

   localparam int unsigned XLEN           = 64;
   localparam int unsigned ILEN           = 32;
   localparam int unsigned REG_IDX_LEN    = 5;
   localparam int unsigned ROB_EXCEPT_LEN = 5;
   // Upper bound on ROB index width carried on the CDB; every ROB instance
   // must have DEPTH <= 2**ROB_IDX_LEN. Unused upper bits must be zero.
   localparam int unsigned ROB_IDX_LEN    = 8;

   // RISC-V synchronous exception causes, as tracked by the ROB
   typedef enum logic [ROB_EXCEPT_LEN-1:0] {
      E_I_ADDR_MISALIGNED  = 5'd0,
      E_I_ACCESS_FAULT     = 5'd1,
      E_ILLEGAL_INSTRUCTION = 5'd2,
      E_BREAKPOINT         = 5'd3,
      E_LD_ADDR_MISALIGNED = 5'd4,
      E_LD_ACCESS_FAULT    = 5'd5,
      E_ST_ADDR_MISALIGNED = 5'd6,
      E_ST_ACCESS_FAULT    = 5'd7,
      E_ENV_CALL_UMODE     = 5'd8,
      E_ENV_CALL_SMODE     = 5'd9,
      E_ENV_CALL_MMODE     = 5'd11,
      E_INSTR_PAGE_FAULT   = 5'd12,
      E_LD_PAGE_FAULT      = 5'd13,
      E_ST_PAGE_FAULT      = 5'd15,
      E_UNKNOWN            = 5'd31
   } except_code_t;

   typedef struct packed {
      logic                   valid;
      logic                   res_ready;
      logic [ILEN-1:0]        instruction;
      logic [XLEN-1:0]        instr_pc;
      logic [REG_IDX_LEN-1:0] rd_idx;
      logic [XLEN-1:0]        res_value;
      logic                   except_raised;
      except_code_t           except_code;
   } rob_mw_entry_t;

   typedef struct packed {
      logic [ROB_IDX_LEN-1:0] rob_idx;
      logic [XLEN-1:0]        res_value;
      logic                   except_raised;
      except_code_t           except_code;
   } cdb_data_t;

endpackage

// File: rtl/rob_mw_commit_sel.sv
// -----------------------------------------------------------------------------
// rob_mw_commit_sel
// Commit lane selection for the reorder buffer. Lane k looks at entry head+k.
//   win_valid_i     : entry in lane k is allocated (and not being squashed)
//   win_res_ready_i : entry in lane k has its result
//   win_except_i    : entry in lane k carries an exception
//   comm_ready_i    : commit logic accepts lane k
//   lane_valid_o    : lane k may be presented for commit
//   npop_o          : number of entries retired this cycle (in-order prefix)
// -----------------------------------------------------------------------------
module rob_mw_commit_sel #(
   parameter  int unsigned COMMIT_W = 2,
   localparam int unsigned NPOP_W   = $clog2(COMMIT_W + 1)
) (
   input  logic [COMMIT_W-1:0] win_valid_i,
   input  logic [COMMIT_W-1:0] win_res_ready_i,
   input  logic [COMMIT_W-1:0] win_except_i,
   input  logic [COMMIT_W-1:0] comm_ready_i,
   output logic [COMMIT_W-1:0] lane_valid_o,
   output logic [NPOP_W-1:0]   npop_o
);

   logic blocked;
   logic prefix;
   logic lane_ok;

   // NOTE: combinational blocks use blocking assignments and give every
   // variable a default first, so no latch can be inferred.
   always_comb begin
      lane_valid_o = '0;
      npop_o       = '0;
      blocked      = 1'b0;
      prefix       = 1'b1;
      lane_ok      = 1'b0;
      for (int k = 0; k < int'(COMMIT_W); k++) begin
         // An excepting entry can only go out on lane 0, and nothing may
         // follow it in the same cycle.
         lane_ok = win_valid_i[k] & win_res_ready_i[k] & ~blocked
                   & ~((k != 0) & win_except_i[k]);
         lane_valid_o[k] = lane_ok;
         blocked = ~lane_ok | win_except_i[k];
      end
      // Retire only the unbroken in-order prefix of accepted lanes.
      for (int k = 0; k < int'(COMMIT_W); k++) begin
         if (prefix && lane_valid_o[k] && comm_ready_i[k]) begin
            npop_o = npop_o + NPOP_W'(1);
         end else begin
            prefix = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rob_mw.sv
// -----------------------------------------------------------------------------
// rob_mw
// Multi-writeback, multi-commit reorder buffer for the LEN5 pipeline.
//   clk_i, rst_n_i        : clock, async active-low reset
//   flush_i               : full flush, clears all state next edge
//   issue_*               : one allocation per cycle, operand lookup by entry
//   cdb_*                 : CDB_PORTS result writebacks per cycle
//   squash_*              : drop every entry younger than squash_idx_i
//   comm_*                : COMMIT_W in-order commit lanes (lane k = head+k)
//   count_o, head_idx_o   : occupancy and head pointer
// -----------------------------------------------------------------------------
module rob_mw
   import expipe_pkg::*;
#(
   parameter  int unsigned DEPTH     = 16,
   parameter  int unsigned COMMIT_W  = 2,
   parameter  int unsigned CDB_PORTS = 2,
   localparam int unsigned IDX_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_n_i,
   input  logic                                  flush_i,
   input  logic                                  issue_valid_i,
   output logic                                  issue_ready_o,
   input  logic [ILEN-1:0]                       issue_instr_i,
   input  logic [XLEN-1:0]                       issue_pc_i,
   input  logic [REG_IDX_LEN-1:0]                issue_rd_idx_i,
   input  logic                                  issue_except_raised_i,
   input  except_code_t                          issue_except_code_i,
   input  logic [XLEN-1:0]                       issue_except_aux_i,
   input  logic                                  issue_res_ready_i,
   input  logic [XLEN-1:0]                       issue_res_value_i,
   output logic [IDX_W-1:0]                      issue_tail_idx_o,
   input  logic [IDX_W-1:0]                      issue_rs1_idx_i,
   input  logic [IDX_W-1:0]                      issue_rs2_idx_i,
   output logic                                  issue_rs1_ready_o,
   output logic                                  issue_rs2_ready_o,
   output logic [XLEN-1:0]                       issue_rs1_value_o,
   output logic [XLEN-1:0]                       issue_rs2_value_o,
   input  logic [CDB_PORTS-1:0]                  cdb_valid_i,
   input  cdb_data_t [CDB_PORTS-1:0]             cdb_data_i,
   output logic                                  cdb_ready_o,
   input  logic                                  squash_valid_i,
   input  logic [IDX_W-1:0]                      squash_idx_i,
   output logic [COMMIT_W-1:0]                   comm_valid_o,
   input  logic [COMMIT_W-1:0]                   comm_ready_i,
   output logic [COMMIT_W-1:0][ILEN-1:0]         comm_instr_o,
   output logic [COMMIT_W-1:0][XLEN-1:0]         comm_pc_o,
   output logic [COMMIT_W-1:0][REG_IDX_LEN-1:0]  comm_rd_idx_o,
   output logic [COMMIT_W-1:0][XLEN-1:0]         comm_value_o,
   output logic [COMMIT_W-1:0]                   comm_except_raised_o,
   output except_code_t [COMMIT_W-1:0]           comm_except_code_o,
   output logic [COMMIT_W-1:0][IDX_W-1:0]        comm_idx_o,
   output logic [CNT_W-1:0]                      count_o,
   output logic [IDX_W-1:0]                      head_idx_o
);

   localparam int unsigned NPOP_W = $clog2(COMMIT_W + 1);

   rob_mw_entry_t             rob_q [DEPTH];
   logic [IDX_W-1:0]          head_q, tail_q;
   logic [CNT_W-1:0]          count_q;
   logic [IDX_W-1:0]          head_d, tail_d;
   logic [CNT_W-1:0]          count_d;

   logic                      push;
   rob_mw_entry_t             push_entry;
   logic [IDX_W-1:0]          sq_age;
   logic [COMMIT_W-1:0]       win_valid, win_res_ready, win_except;
   logic [NPOP_W-1:0]         npop;

   // Age of an entry relative to head, so comparisons survive wrap-around.
   function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] head);
      return idx - head;
   endfunction

   assign sq_age        = age_of(squash_idx_i, head_q);
   assign issue_ready_o = (count_q != CNT_W'(DEPTH)) && !squash_valid_i;
   assign push          = issue_valid_i & issue_ready_o & ~flush_i;
   assign cdb_ready_o   = 1'b1;
   assign count_o       = count_q;
   assign head_idx_o    = head_q;
   assign issue_tail_idx_o = tail_q;

   always_comb begin
      push_entry               = '0;
      push_entry.valid         = 1'b1;
      push_entry.instruction   = issue_instr_i;
      push_entry.instr_pc      = issue_pc_i;
      push_entry.rd_idx        = issue_rd_idx_i;
      push_entry.except_raised = issue_except_raised_i;
      push_entry.except_code   = issue_except_code_i;
      push_entry.res_ready     = issue_except_raised_i | issue_res_ready_i;
      push_entry.res_value     = issue_except_raised_i ? issue_except_aux_i
                                                       : issue_res_value_i;
   end

   // Head window. Lanes being squashed or cut by a flush never commit.
   always_comb begin
      comm_idx_o           = '0;
      win_valid            = '0;
      win_res_ready        = '0;
      win_except           = '0;
      comm_instr_o         = '0;
      comm_pc_o            = '0;
      comm_rd_idx_o        = '0;
      comm_value_o         = '0;
      comm_except_raised_o = '0;
      comm_except_code_o   = {COMMIT_W{E_I_ADDR_MISALIGNED}};
      for (int k = 0; k < int'(COMMIT_W); k++) begin
         comm_idx_o[k]           = head_q + IDX_W'(k);
         win_valid[k]            = rob_q[comm_idx_o[k]].valid & ~flush_i
                                   & ~(squash_valid_i & (IDX_W'(k) > sq_age));
         win_res_ready[k]        = rob_q[comm_idx_o[k]].res_ready;
         win_except[k]           = rob_q[comm_idx_o[k]].except_raised;
         comm_instr_o[k]         = rob_q[comm_idx_o[k]].instruction;
         comm_pc_o[k]            = rob_q[comm_idx_o[k]].instr_pc;
         comm_rd_idx_o[k]        = rob_q[comm_idx_o[k]].rd_idx;
         comm_value_o[k]         = rob_q[comm_idx_o[k]].res_value;
         comm_except_raised_o[k] = rob_q[comm_idx_o[k]].except_raised;
         comm_except_code_o[k]   = rob_q[comm_idx_o[k]].except_code;
      end
   end

   rob_mw_commit_sel #(
      .COMMIT_W (COMMIT_W)
   ) u_commit_sel (
      .win_valid_i     (win_valid),
      .win_res_ready_i (win_res_ready),
      .win_except_i    (win_except),
      .comm_ready_i    (comm_ready_i),
      .lane_valid_o    (comm_valid_o),
      .npop_o          (npop)
   );

   // Operand lookup with same-cycle CDB forwarding.
   always_comb begin
      issue_rs1_ready_o = rob_q[issue_rs1_idx_i].res_ready;
      issue_rs1_value_o = rob_q[issue_rs1_idx_i].res_value;
      issue_rs2_ready_o = rob_q[issue_rs2_idx_i].res_ready;
      issue_rs2_value_o = rob_q[issue_rs2_idx_i].res_value;
      for (int p = 0; p < int'(CDB_PORTS); p++) begin
         if (cdb_valid_i[p] && cdb_data_i[p].rob_idx == ROB_IDX_LEN'(issue_rs1_idx_i)) begin
            issue_rs1_ready_o = 1'b1;
            issue_rs1_value_o = cdb_data_i[p].res_value;
         end
         if (cdb_valid_i[p] && cdb_data_i[p].rob_idx == ROB_IDX_LEN'(issue_rs2_idx_i)) begin
            issue_rs2_ready_o = 1'b1;
            issue_rs2_value_o = cdb_data_i[p].res_value;
         end
      end
   end

   always_comb begin
      head_d = head_q + IDX_W'(npop);
      if (squash_valid_i) begin
         tail_d  = squash_idx_i + IDX_W'(1);
         count_d = CNT_W'(sq_age) + CNT_W'(1) - CNT_W'(npop);
      end else begin
         tail_d  = tail_q + IDX_W'(push);
         count_d = count_q + CNT_W'(push) - CNT_W'(npop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Later
   // assignments to the same entry field take precedence within the edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         // NOTE: only the control bits of the entry array are reset; the
         // payload is never read before an allocation overwrites it.
         for (int i = 0; i < int'(DEPTH); i++) begin
            rob_q[i].valid         <= 1'b0;
            rob_q[i].res_ready     <= 1'b0;
            rob_q[i].except_raised <= 1'b0;
         end
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            rob_q[i].valid         <= 1'b0;
            rob_q[i].res_ready     <= 1'b0;
            rob_q[i].except_raised <= 1'b0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (k < int'(npop)) rob_q[comm_idx_o[k]].valid <= 1'b0;
         end
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (squash_valid_i && (age_of(IDX_W'(i), head_q) > sq_age)) begin
               rob_q[i].valid <= 1'b0;
            end
            for (int p = 0; p < int'(CDB_PORTS); p++) begin
               if (cdb_valid_i[p] && rob_q[i].valid &&
                   cdb_data_i[p].rob_idx == ROB_IDX_LEN'(i)) begin
                  rob_q[i].res_ready     <= 1'b1;
                  rob_q[i].res_value     <= cdb_data_i[p].res_value;
                  rob_q[i].except_raised <= cdb_data_i[p].except_raised;
                  rob_q[i].except_code   <= cdb_data_i[p].except_code;
               end
            end
         end
         // The tail entry is free, so no commit or CDB update competes here.
         if (push) rob_q[tail_q] <= push_entry;
      end
   end

`ifndef SYNTHESIS
   for (genvar p = 0; p < int'(CDB_PORTS); p++) begin : g_cdb_a
      for (genvar q = p + 1; q < int'(CDB_PORTS); q++) begin : g_pair
         a_cdb_distinct: assert property (@(posedge clk_i) disable iff (!rst_n_i)
            !(cdb_valid_i[p] && cdb_valid_i[q] &&
              cdb_data_i[p].rob_idx == cdb_data_i[q].rob_idx));
      end
   end

   a_squash_target_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (squash_valid_i && !flush_i) |-> rob_q[squash_idx_i].valid);
`endif

endmodule
